// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared memory port.
// Optional RV_CTRL_PERF_EN adds cycle_cnt / instret_cnt performance counters.
module rv32i_mc_ctrl #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
`ifdef RV_CTRL_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd7
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [31:0] TMO_LAST = (MEM_TIMEOUT == 0) ? 32'd0 : 32'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [31:0] tmo;
  logic        legal, tmo_hit;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Counts consecutive wait cycles in FETCH/MEM; zero on every state entry.
  assign tmo_hit = (MEM_TIMEOUT != 0) && !mem_ready && (tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      illegal <= 1'b0;
      tmo     <= '0;
    end else begin
      tmo <= ((state == FETCH || state == MEM) && !mem_ready && !tmo_hit) ? tmo + 32'd1 : 32'd0;
      case (state)
        FETCH: begin
          if (mem_ready)    state <= DECODE;
          else if (tmo_hit) begin state <= TRAP; illegal <= 1'b1; end
        end
        DECODE: begin
          if (legal) state <= EXEC;
          else begin state <= TRAP; illegal <= 1'b1; end
        end
        EXEC: begin
          case (opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: state <= WB;
            OP_LOAD, OP_STORE:            state <= MEM;
            default:                      state <= FETCH;
          endcase
        end
        MEM: begin
          if (mem_ready)    state <= (opcode == OP_LOAD) ? WB : FETCH;
          else if (tmo_hit) begin state <= TRAP; illegal <= 1'b1; end
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: begin state <= TRAP; illegal <= 1'b1; end
      endcase
    end
  end

  // Outputs are decoded from state and IR fields; all forced low while in reset.
  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; mem_addr_sel = 1'b0; ir_we = 1'b0;
    pc_we = 1'b0; pc_sel = 2'd0; alu_a_sel = 1'b0; alu_b_sel = 1'b0;
    alu_op = 4'd0; reg_we = 1'b0; wb_sel = 2'd0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        EXEC: begin
          case (opcode)
            OP_R: alu_op = {funct7b5, funct3};
            OP_I: begin
              alu_b_sel = 1'b1;
              alu_op    = {(funct3 == 3'b101) & funct7b5, funct3};
            end
            OP_LOAD, OP_STORE: alu_b_sel = 1'b1;
            OP_BR: begin
              alu_op = 4'b1000;
              pc_we  = 1'b1;
              pc_sel = branch_taken ? 2'd1 : 2'd0;
            end
            OP_JAL:  begin reg_we = 1'b1; wb_sel = 2'd2; pc_we = 1'b1; pc_sel = 2'd1; end
            OP_JALR: begin reg_we = 1'b1; wb_sel = 2'd2; pc_we = 1'b1; pc_sel = 2'd2; end
            OP_AUIPC: begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; end
            default: ;
          endcase
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_STORE);
          pc_we        = mem_ready && (opcode == OP_STORE);
        end
        WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          wb_sel = (opcode == OP_LOAD) ? 2'd1 : (opcode == OP_LUI) ? 2'd3 : 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

`ifdef RV_CTRL_PERF_EN
  // pc_we is high exactly on the EXEC/MEM/WB -> FETCH transitions, i.e. on retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we)         instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed bench for rv32i_mc_ctrl: per-cycle vector table plus reset/timeout sequences.
module tb_rv32i_mc_ctrl;
  logic clk = 1'b0, rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7b5, branch_taken, mem_ready;

  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_a_sel, alu_b_sel, reg_we, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] alu_op;
  logic [2:0] state_o;

  logic t_mem_req, t_mem_we, t_mem_addr_sel, t_ir_we, t_pc_we, t_alu_a_sel, t_alu_b_sel;
  logic t_reg_we, t_illegal;
  logic [1:0] t_pc_sel, t_wb_sel;
  logic [3:0] t_alu_op;
  logic [2:0] t_state_o;

  logic [16:0] outs, t_outs;
  assign outs   = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                   alu_op, reg_we, wb_sel, illegal};
  assign t_outs = {t_mem_req, t_mem_we, t_mem_addr_sel, t_ir_we, t_pc_we, t_pc_sel, t_alu_a_sel,
                   t_alu_b_sel, t_alu_op, t_reg_we, t_wb_sel, t_illegal};

  rv32i_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel(wb_sel), .illegal(illegal), .state_o(state_o));

  rv32i_mc_ctrl #(.MEM_TIMEOUT(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(t_mem_req), .mem_we(t_mem_we),
    .mem_addr_sel(t_mem_addr_sel), .ir_we(t_ir_we), .pc_we(t_pc_we), .pc_sel(t_pc_sel),
    .alu_a_sel(t_alu_a_sel), .alu_b_sel(t_alu_b_sel), .alu_op(t_alu_op), .reg_we(t_reg_we),
    .wb_sel(t_wb_sel), .illegal(t_illegal), .state_o(t_state_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        bt;
    logic        mr;
    logic [2:0]  st;
    logic [16:0] out;
  } vec_t;

  vec_t tv[64];
  int n = 0;
  int checks = 0, fails = 0;

  function automatic logic [16:0] o(input logic req, we, as, irw, pcw, input logic [1:0] pcs,
                                    input logic aa, ab, input logic [3:0] aop, input logic rw,
                                    input logic [1:0] wbs, input logic ill);
    return {req, we, as, irw, pcw, pcs, aa, ab, aop, rw, wbs, ill};
  endfunction

  task automatic add(input logic [31:0] ir, input logic bt, mr, input logic [2:0] st,
                     input logic [16:0] out);
    tv[n] = '{ir, bt, mr, st, out};
    n++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setir(input logic [31:0] ir);
    opcode = ir[6:0]; funct3 = ir[14:12]; funct7b5 = ir[30];
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  logic [16:0] of, ofw, o0, otrap;

  initial begin
    of    = o(1,0,0,1,0,2'd0,0,0,4'd0,0,2'd0,0);
    ofw   = o(1,0,0,0,0,2'd0,0,0,4'd0,0,2'd0,0);
    o0    = '0;
    otrap = o(0,0,0,0,0,2'd0,0,0,4'd0,0,2'd0,1);

    // add x3,x1,x2
    add(32'h002081B3,0,1,3'd0,of); add(32'h002081B3,0,1,3'd1,o0); add(32'h002081B3,0,1,3'd2,o0);
    add(32'h002081B3,0,1,3'd4,o(0,0,0,0,1,2'd0,0,0,4'd0,1,2'd0,0));
    // sub: funct7b5 feeds alu_op[3]
    add(32'h402081B3,0,1,3'd0,of); add(32'h402081B3,0,1,3'd1,o0);
    add(32'h402081B3,0,1,3'd2,o(0,0,0,0,0,2'd0,0,0,4'd8,0,2'd0,0));
    add(32'h402081B3,0,1,3'd4,o(0,0,0,0,1,2'd0,0,0,4'd0,1,2'd0,0));
    // lw with one fetch wait and two MEM waits
    add(32'h02812183,0,0,3'd0,ofw); add(32'h02812183,0,1,3'd0,of); add(32'h02812183,0,1,3'd1,o0);
    add(32'h02812183,0,1,3'd2,o(0,0,0,0,0,2'd0,0,1,4'd0,0,2'd0,0));
    add(32'h02812183,0,0,3'd3,o(1,0,1,0,0,2'd0,0,0,4'd0,0,2'd0,0));
    add(32'h02812183,0,0,3'd3,o(1,0,1,0,0,2'd0,0,0,4'd0,0,2'd0,0));
    add(32'h02812183,0,1,3'd3,o(1,0,1,0,0,2'd0,0,0,4'd0,0,2'd0,0));
    add(32'h02812183,0,1,3'd4,o(0,0,0,0,1,2'd0,0,0,4'd0,1,2'd1,0));
    // sw with one MEM wait
    add(32'h0220ABA3,0,1,3'd0,of); add(32'h0220ABA3,0,1,3'd1,o0);
    add(32'h0220ABA3,0,1,3'd2,o(0,0,0,0,0,2'd0,0,1,4'd0,0,2'd0,0));
    add(32'h0220ABA3,0,0,3'd3,o(1,1,1,0,0,2'd0,0,0,4'd0,0,2'd0,0));
    add(32'h0220ABA3,0,1,3'd3,o(1,1,1,0,1,2'd0,0,0,4'd0,0,2'd0,0));
    // beq taken / not taken
    add(32'h02208E63,1,1,3'd0,of); add(32'h02208E63,1,1,3'd1,o0);
    add(32'h02208E63,1,1,3'd2,o(0,0,0,0,1,2'd1,0,0,4'd8,0,2'd0,0));
    add(32'h02208E63,0,1,3'd0,of); add(32'h02208E63,0,1,3'd1,o0);
    add(32'h02208E63,0,1,3'd2,o(0,0,0,0,1,2'd0,0,0,4'd8,0,2'd0,0));
    // jal, jalr
    add(32'hF9DFF16F,0,1,3'd0,of); add(32'hF9DFF16F,0,1,3'd1,o0);
    add(32'hF9DFF16F,0,1,3'd2,o(0,0,0,0,1,2'd1,0,0,4'd0,1,2'd2,0));
    add(32'h00008067,0,1,3'd0,of); add(32'h00008067,0,1,3'd1,o0);
    add(32'h00008067,0,1,3'd2,o(0,0,0,0,1,2'd2,0,0,4'd0,1,2'd2,0));
    // lui
    add(32'h51000137,0,1,3'd0,of); add(32'h51000137,0,1,3'd1,o0); add(32'h51000137,0,1,3'd2,o0);
    add(32'h51000137,0,1,3'd4,o(0,0,0,0,1,2'd0,0,0,4'd0,1,2'd3,0));
    // auipc
    add(32'h00000097,0,1,3'd0,of); add(32'h00000097,0,1,3'd1,o0);
    add(32'h00000097,0,1,3'd2,o(0,0,0,0,0,2'd0,1,1,4'd0,0,2'd0,0));
    add(32'h00000097,0,1,3'd4,o(0,0,0,0,1,2'd0,0,0,4'd0,1,2'd0,0));
    // srai: sra bit passes through for funct3=101
    add(32'h4030D093,0,1,3'd0,of); add(32'h4030D093,0,1,3'd1,o0);
    add(32'h4030D093,0,1,3'd2,o(0,0,0,0,0,2'd0,0,1,4'd13,0,2'd0,0));
    add(32'h4030D093,0,1,3'd4,o(0,0,0,0,1,2'd0,0,0,4'd0,1,2'd0,0));
    // addi with imm bit 30 set: must not become a subtract
    add(32'hC0000093,0,1,3'd0,of); add(32'hC0000093,0,1,3'd1,o0);
    add(32'hC0000093,0,1,3'd2,o(0,0,0,0,0,2'd0,0,1,4'd0,0,2'd0,0));
    add(32'hC0000093,0,1,3'd4,o(0,0,0,0,1,2'd0,0,0,4'd0,1,2'd0,0));
    // illegal opcode, then TRAP holds with mem_ready high
    add(32'h0000007F,0,1,3'd0,of); add(32'h0000007F,0,1,3'd1,o0);
    add(32'h0000007F,0,1,3'd7,otrap); add(32'h0000007F,0,1,3'd7,otrap);
    add(32'h0000007F,0,1,3'd7,otrap);

    rst_n = 1'b0; setir(32'h002081B3); branch_taken = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_outs", 32'(outs), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < n; i++) begin
      setir(tv[i].ir); branch_taken = tv[i].bt; mem_ready = tv[i].mr;
      #1;
      chk($sformatf("row%0d_state", i), 32'(state_o), 32'(tv[i].st));
      chk($sformatf("row%0d_outs", i), 32'(outs), 32'(tv[i].out));
      if (pc_we && ir_we) chk($sformatf("row%0d_pc_ir_excl", i), 32'd1, 32'd0);
      @(posedge clk); #1;
    end

    // Reset out of TRAP, then fetch stall: the timeout instance traps after 3 waits.
    rst_n = 1'b0; #1;
    chk("trap_reset_illegal", 32'(illegal), 32'd0);
    chk("trap_reset_state", 32'(state_o), 32'd0);
    step(); rst_n = 1'b1; mem_ready = 1'b0; setir(32'h002081B3);
    #1;
    chk("stall0_outs", 32'(outs), 32'(ofw));
    step(); step();
    chk("tmo_2wait_state", 32'(t_state_o), 32'd0);
    chk("tmo_2wait_outs", 32'(t_outs), 32'(ofw));
    step();
    chk("tmo_trap_state", 32'(t_state_o), 32'd7);
    chk("tmo_trap_outs", 32'(t_outs), 32'(otrap));
    chk("notmo_state", 32'(state_o), 32'd0);
    chk("notmo_req", 32'(mem_req), 32'd1);

    // Asynchronous reset mid-FETCH drops mem_req without waiting for a clock edge.
    #2 rst_n = 1'b0; #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_outs", 32'(outs), 32'd0);
    chk("midrst_t_illegal", 32'(t_illegal), 32'd0);
    step(); rst_n = 1'b1; mem_ready = 1'b1; #1;
    chk("recover_fetch", 32'(outs), 32'(of));
    step();
    chk("recover_decode", 32'(state_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over a shared single-port instruction/data memory. It drives datapath selects and enables: PC, IR, register file, ALU, and the memory address mux. Opcode and funct fields come from the IR, and the branch decision comes from the datapath comparator.

Parameters:
MEM_TIMEOUT, 0, if nonzero: cycles waiting on mem_ready before entering TRAP; 0 = wait forever

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
branch_taken  in  1  comparator result for current funct3
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  store when mem_req
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  latch fetched word into IR
pc_we  out  1  update PC
pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1
alu_a_sel  out  1  0 = rs1, 1 = PC
alu_b_sel  out  1  0 = rs2, 1 = imm
alu_op  out  4  {sub/sra bit, funct3}
reg_we  out  1  register file write
wb_sel  out  2  0 = ALU, 1 = mem data, 2 = PC+4, 3 = imm
illegal  out  1  sticky illegal-instruction / timeout flag
state_o  out  3  current state for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Reset (rst_n low, async): state=FETCH. All outputs 0 except mem_req. mem_req is combinational from state, so it rises in the first cycle after reset release; it is low while reset is asserted. Reset mid-transaction drops mem_req immediately and abandons the access.
- Outputs are combinational from state plus decoded fields. No output is registered except state and illegal.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ready: ir_we=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, all enables 0 (regfile read, imm gen settle).
  - Illegal opcode goes to TRAP.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- EXEC, by opcode:
  - R (0110011): alu_a_sel=0, alu_b_sel=0, alu_op={funct7b5,funct3}; go to WB.
  - I-ALU (0010011): alu_b_sel=1; alu_op={funct3==101 ? funct7b5 : 0, funct3}; go to WB.
  - LOAD/STORE: alu_b_sel=1, alu_op=0000; go to MEM.
  - BRANCH: alu_op=1000, pc_we=1, pc_sel = branch_taken ? 1 : 0; go to FETCH.
  - JAL: reg_we=1, wb_sel=2, pc_we=1, pc_sel=1; go to FETCH.
  - JALR: reg_we=1, wb_sel=2, pc_we=1, pc_sel=2; go to FETCH.
  - LUI: go to WB with wb_sel=3.
  - AUIPC: alu_a_sel=1, alu_b_sel=1, alu_op=0000; go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we = (opcode==STORE). On mem_ready:
  - Load goes to WB.
  - Store asserts pc_we=1, pc_sel=0, and goes to FETCH.
- WB: reg_we=1, wb_sel per opcode (load 1, LUI 3, else 0), pc_we=1, pc_sel=0; go to FETCH.
- TRAP: illegal=1, all enables 0, stays until reset.
- Latency with zero-wait memory:
  - R/I/LUI/AUIPC and store: 4 cycles.
  - Load: 5 cycles.
  - Branch, JAL, JALR: 3 cycles.
  - Each memory wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.
- pc_we and ir_we are never high in the same cycle.
- MEM_TIMEOUT: counter resets on state entry. Reaching MEM_TIMEOUT cycles in FETCH/MEM without mem_ready goes to TRAP.

Optional Feature:
RV_CTRL_PERF_EN:
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - cycle_cnt increments every cycle not in TRAP.
  - instret_cnt increments on every transition into FETCH from EXEC, MEM or WB.
- Undefined: the ports and counters are absent.

Test Plan:
- Reset, then mem_ready=1 each cycle, IR=0x002081B3 (add x3,x1,x2) -> states 0,1,2,4. EXEC alu_op=0000; WB reg_we=1, wb_sel=0, pc_we=1, pc_sel=0.
- IR=0x02812183 (lw x3,40(x2)), mem_ready low for 2 MEM cycles -> mem_req=1, mem_addr_sel=1, mem_we=0 held 3 cycles. Then WB with wb_sel=1; total 7 cycles.
- IR=0x0220ABA3 (sw) -> MEM mem_we=1, then pc_we=1 and back to FETCH; reg_we never 1.
- IR=0x02208E63 (beq) with branch_taken=1 -> EXEC pc_sel=1, pc_we=1. Repeat with branch_taken=0 -> pc_sel=0.
- IR=0xF9DFF16F (jal x2,-100) -> EXEC reg_we=1, wb_sel=2, pc_sel=1. IR=0x51000137 (lui) -> WB wb_sel=3.
- IR=0x0000007F -> TRAP, illegal=1 held. rst_n low mid-FETCH -> mem_req=0 immediately, state=0, illegal=0.
